led_blink_ctrl: RTL and testbench

Parametrised multi-channel LED controller, the successor to the single free-running-counter LED blinker. A shared prescaler produces a slow tick. Each of CH channels runs its own phase counter against a programmable period and on-time, in OFF, ON, BLINK or ONESHOT mode. It sits between board-level LED pins and a simple register-write strobe from control logic.

---
 rtl/led_pkg.sv | 14 +
 rtl/led_blink_ctrl_if.sv | 23 ++
 rtl/led_chan.sv | 118 +++++++++++
 rtl/led_blink_ctrl.sv | 55 +++++
 tb/tb_led_blink_ctrl.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/led_pkg.sv
// Shared types for the multi-channel LED controller: channel mode encoding
// and its width.
package led_pkg;

  localparam int LED_MODE_W = 2;

  typedef enum logic [LED_MODE_W-1:0] {
    LED_OFF     = 2'd0,
    LED_ON      = 2'd1,
    LED_BLINK   = 2'd2,
    LED_ONESHOT = 2'd3
  } led_mode_t;

endpackage

// File: rtl/led_blink_ctrl_if.sv
// Configuration write bus for led_blink_ctrl: one-cycle strobe that carries
// the target channel, mode, period and on-time.
interface led_blink_ctrl_if #(
  parameter int CH    = 4,
  parameter int PER_W = 8
);
  import led_pkg::*;

  logic                    cfg_we;
  logic [$clog2(CH)-1:0]   cfg_ch;
  logic [LED_MODE_W-1:0]   cfg_mode;
  logic [PER_W-1:0]        cfg_period;
  logic [PER_W-1:0]        cfg_on;

  modport master (
    output cfg_we, cfg_ch, cfg_mode, cfg_period, cfg_on
  );

  modport slave (
    input  cfg_we, cfg_ch, cfg_mode, cfg_period, cfg_on
  );

endinterface

// File: rtl/led_chan.sv
// One LED channel: mode/period/on/phase registers, phase counter and the
// registered LED drive. ONESHOT support is built only with LED_ONESHOT_EN.
module led_chan
  import led_pkg::*;
#(
  parameter int PER_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tick,
  input  logic                  we,
  input  logic [LED_MODE_W-1:0] wr_mode,
  input  logic [PER_W-1:0]      wr_period,
  input  logic [PER_W-1:0]      wr_on,
  output logic                  led,
  output logic                  busy
);

  led_mode_t        mode_q,   mode_nxt;
  logic [PER_W-1:0] period_q, period_nxt;
  logic [PER_W-1:0] on_q,     on_nxt;
  logic [PER_W-1:0] phase_q,  phase_nxt;
  logic             led_q,    led_nxt;
  led_mode_t        wr_mode_dec;

`ifdef LED_ONESHOT_EN
  logic [PER_W:0]   phase_inc;
  assign phase_inc   = {1'b0, phase_q} + (PER_W+1)'(1);
  assign wr_mode_dec = led_mode_t'(wr_mode);
`else
  // Without ONESHOT support a mode 3 write parks the channel in OFF.
  assign wr_mode_dec = (wr_mode == LED_ONESHOT) ? LED_OFF : led_mode_t'(wr_mode);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= LED_OFF;
      period_q <= '0;
      on_q     <= '0;
      phase_q  <= '0;
      led_q    <= 1'b0;
    end else begin
      mode_q   <= mode_nxt;
      period_q <= period_nxt;
      on_q     <= on_nxt;
      phase_q  <= phase_nxt;
      led_q    <= led_nxt;
    end
  end

  always_comb begin
    mode_nxt   = mode_q;
    period_nxt = period_q;
    on_nxt     = on_q;
    phase_nxt  = phase_q;
    led_nxt    = 1'b0;

    case (mode_q)
      LED_OFF: begin
        phase_nxt = '0;
        led_nxt   = 1'b0;
      end
      LED_ON: begin
        phase_nxt = '0;
        led_nxt   = 1'b1;
      end
      LED_BLINK: begin
        if (tick) begin
          phase_nxt = (phase_q == period_q) ? '0 : phase_q + PER_W'(1);
        end
        led_nxt = (phase_q < on_q);
      end
      LED_ONESHOT: begin
`ifdef LED_ONESHOT_EN
        // Zero on-time reverts immediately; otherwise revert on the tick
        // that would carry the phase past the on-time.
        if (on_q == '0) begin
          mode_nxt  = LED_OFF;
          phase_nxt = '0;
        end else if (tick) begin
          if (phase_inc >= {1'b0, on_q}) begin
            mode_nxt  = LED_OFF;
            phase_nxt = '0;
          end else begin
            phase_nxt = phase_inc[PER_W-1:0];
          end
        end
        led_nxt = (phase_q < on_q);
`else
        mode_nxt  = LED_OFF;
        phase_nxt = '0;
        led_nxt   = 1'b0;
`endif
      end
      default: begin
        mode_nxt  = LED_OFF;
        phase_nxt = '0;
      end
    endcase

    // A write overrides any same-cycle tick advance.
    if (we) begin
      mode_nxt   = wr_mode_dec;
      period_nxt = wr_period;
      on_nxt     = wr_on;
      phase_nxt  = '0;
    end
  end

  assign led = led_q;

`ifdef LED_ONESHOT_EN
  assign busy = (mode_q == LED_ONESHOT);
`else
  assign busy = 1'b0;
`endif

endmodule

// File: rtl/led_blink_ctrl.sv
// Multi-channel LED controller top: shared tick prescaler, write-address decode
// and CH led_chan instances. Define LED_ONESHOT_EN to enable ONESHOT mode.
module led_blink_ctrl
  import led_pkg::*;
#(
  parameter int CH        = 4,
  parameter int PRESC_DIV = 1000,
  parameter int CNT_W     = 29,
  parameter int PER_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  led_blink_ctrl_if.slave      cfg,
  output logic [CNT_W-1:0]     count,
  output logic                 tick,
  output logic [CH-1:0]        led,
  output logic [CH-1:0]        busy
);

  localparam int               CHW     = $clog2(CH);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRESC_DIV - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (count == CNT_MAX) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  assign tick = (count == CNT_MAX);

  // An index with no matching channel selects nothing, so it is dropped.
  for (genvar i = 0; i < CH; i++) begin : g_chan
    logic chan_we;
    assign chan_we = cfg.cfg_we && (cfg.cfg_ch == CHW'(i));

    led_chan #(
      .PER_W (PER_W)
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .tick      (tick),
      .we        (chan_we),
      .wr_mode   (cfg.cfg_mode),
      .wr_period (cfg.cfg_period),
      .wr_on     (cfg.cfg_on),
      .led       (led[i]),
      .busy      (busy[i])
    );
  end

endmodule

// File: tb/tb_led_blink_ctrl.sv
// Directed bench for led_blink_ctrl (CH=4, PRESC_DIV=4) plus a CH=3 instance
// used to exercise an out-of-range channel index.
module tb_led_blink_ctrl;
  import led_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  led_blink_ctrl_if #(.CH(4), .PER_W(8)) cfg_if ();
  led_blink_ctrl_if #(.CH(3), .PER_W(8)) cfg3_if ();

  logic [3:0] count;
  logic       tick;
  logic [3:0] led;
  logic [3:0] busy;
  logic [3:0] count3;
  logic       tick3;
  logic [2:0] led3;
  logic [2:0] busy3;

  led_blink_ctrl #(
    .CH(4), .PRESC_DIV(4), .CNT_W(4), .PER_W(8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cfg   (cfg_if),
    .count (count),
    .tick  (tick),
    .led   (led),
    .busy  (busy)
  );

  led_blink_ctrl #(
    .CH(3), .PRESC_DIV(4), .CNT_W(4), .PER_W(8)
  ) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .cfg   (cfg3_if),
    .count (count3),
    .tick  (tick3),
    .led   (led3),
    .busy  (busy3)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tick();
    for (int k = 0; k < 8; k++) begin
      if (tick) break;
      step();
    end
    check("tick_seen", 32'(tick), 32'd1);
  endtask

  task automatic write(input logic [1:0] ch, input logic [1:0] mode,
                       input logic [7:0] per, input logic [7:0] on);
    cfg_if.cfg_ch     = ch;
    cfg_if.cfg_mode   = mode;
    cfg_if.cfg_period = per;
    cfg_if.cfg_on     = on;
    cfg_if.cfg_we     = 1'b1;
    step();
    cfg_if.cfg_we     = 1'b0;
  endtask

  initial begin
    cfg_if.cfg_we      = 1'b0;
    cfg_if.cfg_ch      = '0;
    cfg_if.cfg_mode    = '0;
    cfg_if.cfg_period  = '0;
    cfg_if.cfg_on      = '0;
    cfg3_if.cfg_we     = 1'b0;
    cfg3_if.cfg_ch     = '0;
    cfg3_if.cfg_mode   = '0;
    cfg3_if.cfg_period = '0;
    cfg3_if.cfg_on     = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_led",   32'(led),   32'd0);
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_tick",  32'(tick),  32'd0);
    check("rst_led3",  32'(led3),  32'd0);

    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      check("presc_count", 32'(count), 32'(k % 4));
      check("presc_tick",  32'(tick),  32'((k % 4) == 3));
    end

    // BLINK on ch0: period 3, on 2, written in a tick cycle
    wait_tick();
    write(2'd0, 2'd2, 8'd3, 8'd2);
    check("blink_lat", 32'(led[0]), 32'd0);
    for (int j = 1; j <= 32; j++) begin
      step();
      check("blink_led0", 32'(led[0]), 32'((((j - 1) / 8) % 2) == 0));
      if (j % 8 == 0) check("blink_others", 32'(led[3:1]), 32'd0);
    end

    // ON then OFF on ch1
    write(2'd1, 2'd1, 8'd0, 8'd0);
    check("on_e0", 32'(led[1]), 32'd0);
    step();
    check("on_e1", 32'(led[1]), 32'd1);
    write(2'd1, 2'd0, 8'd0, 8'd0);
    check("off_e0", 32'(led[1]), 32'd1);
    step();
    check("off_e1", 32'(led[1]), 32'd0);

    // ONESHOT on ch2, on 3, written in a tick cycle
    wait_tick();
    write(2'd2, 2'd3, 8'd0, 8'd3);
`ifdef LED_ONESHOT_EN
    check("os_busy_e0", 32'(busy[2]), 32'd1);
    check("os_led_e0",  32'(led[2]),  32'd0);
    for (int j = 1; j <= 14; j++) begin
      step();
      check("os_led",  32'(led[2]),  32'(j <= 12));
      check("os_busy", 32'(busy[2]), 32'(j < 12));
    end
`else
    check("os_dis_busy_e0", 32'(busy), 32'd0);
    for (int j = 1; j <= 14; j++) begin
      step();
      check("os_dis_led",  32'(led[2]), 32'd0);
      check("os_dis_busy", 32'(busy),   32'd0);
    end
`endif

    // Collision: rewrite ch0 on the tick that would take phase 2 -> 3
    wait_tick();
    write(2'd0, 2'd2, 8'd3, 8'd2);
    repeat (8) step();
    check("col_pre", 32'(led[0]), 32'd1);
    wait_tick();
    write(2'd0, 2'd2, 8'd3, 8'd2);
    check("col_e0", 32'(led[0]), 32'd0);
    for (int j = 1; j <= 9; j++) begin
      step();
      check("col_led0", 32'(led[0]), 32'(j <= 8));
    end

    // Out-of-range index on the CH=3 instance
    cfg3_if.cfg_ch   = 2'd3;
    cfg3_if.cfg_mode = 2'd1;
    cfg3_if.cfg_we   = 1'b1;
    step();
    cfg3_if.cfg_we   = 1'b0;
    step();
    check("range_ignored", 32'(led3), 32'd0);
    cfg3_if.cfg_ch   = 2'd2;
    cfg3_if.cfg_we   = 1'b1;
    step();
    cfg3_if.cfg_we   = 1'b0;
    step();
    check("range_ch2", 32'(led3), 32'b100);

    // Mid-run reset during a BLINK high phase
    wait_tick();
    write(2'd0, 2'd2, 8'd3, 8'd2);
    step();
    check("mr_pre", 32'(led[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mr_led",   32'(led),   32'd0);
    check("mr_busy",  32'(busy),  32'd0);
    check("mr_count", 32'(count), 32'd0);
    check("mr_tick",  32'(tick),  32'd0);
    check("mr_led3",  32'(led3),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 1; j <= 12; j++) begin
      step();
      check("mr_after", 32'(led), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
